// File: rtl/dnn_feeder_pkg.sv
// Shared sizing constants, helper functions and state type for the DNN
// training-data feeder.
package dnn_feeder_pkg;

  // Clocks per cycle block: one clock per activation chunk plus two drain clocks.
  function automatic int calc_cpc(input int n, input int fo, input int z);
    return (n * fo) / z + 2;
  endfunction

  function automatic int chunk_count(input int n, input int w);
    return n / w;
  endfunction

  localparam int N_IN      = 64;
  localparam int N_OUT     = 4;
  localparam int AIN_W     = 16;
  localparam int YIN_W     = 1;
  localparam int MAX_CASES = 32;
  localparam int EP_W      = 16;
  localparam int CPC       = calc_cpc(N_IN, 1, AIN_W);
  localparam int CASE_W    = $clog2(MAX_CASES);
  localparam int NC_W      = $clog2(MAX_CASES + 1);
  localparam int CI_W      = $clog2(CPC);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/train_data_feeder_if.sv
// Case-buffer write port, run control and DNN-facing stream of the feeder.
interface train_data_feeder_if;
  import dnn_feeder_pkg::*;

  logic              wr_en;
  logic [CASE_W-1:0] wr_addr;
  logic [N_IN-1:0]   wr_a;
  logic [N_OUT-1:0]  wr_y;
  logic              wr_err;
  logic              start;
  logic              stop;
  logic [NC_W-1:0]   num_cases;
  logic [EP_W-1:0]   num_epochs;
  logic [AIN_W-1:0]  a_in;
  logic [YIN_W-1:0]  y_in;
  logic              valid;
  logic              case_start;
  logic [CI_W-1:0]   cycle_index;
  logic [CASE_W-1:0] case_idx;
  logic [EP_W-1:0]   epoch;
  logic              busy;
  logic              done;

  modport master (
    output wr_en, wr_addr, wr_a, wr_y, start, stop, num_cases, num_epochs,
    input  wr_err, a_in, y_in, valid, case_start, cycle_index, case_idx, epoch, busy, done
  );

  modport slave (
    input  wr_en, wr_addr, wr_a, wr_y, start, stop, num_cases, num_epochs,
    output wr_err, a_in, y_in, valid, case_start, cycle_index, case_idx, epoch, busy, done
  );

endinterface

// File: rtl/cycle_block_counter.sv
// Free-running position counter within a DNN cycle block of CPC clocks;
// o_cycle_clk marks the last clock of each block.
module cycle_block_counter #(
  parameter int CPC  = 6,
  parameter int CI_W = 3
) (
  input  logic            i_clk,
  input  logic            i_reset,
  output logic [CI_W-1:0] o_cycle_index,
  output logic            o_cycle_clk
);

  logic [CI_W-1:0] r_cnt;

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_cnt <= '0;
    end else if (r_cnt == CI_W'(CPC - 1)) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + CI_W'(1);
    end
  end

  assign o_cycle_index = r_cnt;
  assign o_cycle_clk   = (r_cnt == CI_W'(CPC - 1));

endmodule

// File: rtl/train_data_feeder.sv
// Replays buffered 1-bit training cases to the DNN as MSB-first chunks, one
// case per cycle block, epoch after epoch, until the epoch limit or a stop.
module train_data_feeder (
  input  logic clk,
  input  logic reset,
  train_data_feeder_if.slave bus
);
  import dnn_feeder_pkg::*;

  localparam int BUF_W = N_IN + N_OUT;

  if ((chunk_count(N_IN, AIN_W) != CPC - 2) || (chunk_count(N_OUT, YIN_W) != CPC - 2)) begin : g_bad_cfg
    $error("train_data_feeder: chunk counts of a and y must both equal cpc-2");
  end

  logic [BUF_W-1:0]  r_buf [MAX_CASES];
  state_e            r_state;
  logic              r_pend, r_stop, r_valid, r_case_start, r_wr_err;
  logic [NC_W-1:0]   r_num_cases;
  logic [EP_W-1:0]   r_num_epochs, r_epoch;
  logic [CASE_W-1:0] r_case_idx;
  logic [N_IN-1:0]   r_sh_a;
  logic [N_OUT-1:0]  r_sh_y;
  logic [AIN_W-1:0]  r_a_in;
  logic [YIN_W-1:0]  r_y_in;

  logic              w_busy, w_last, w_case_last, w_has_chunk, w_end_run;
  logic [CI_W-1:0]   w_ci, w_nk, w_sel;
  logic [CASE_W-1:0] w_next_idx, w_rd_idx;
  logic [EP_W-1:0]   w_epoch_inc;
  logic [BUF_W-1:0]  w_rd;

  assign w_busy = (r_state == RUN);

  cycle_block_counter #(.CPC(CPC), .CI_W(CI_W)) u_cbc (
    .i_clk         (clk),
    .i_reset       (reset | ~w_busy),
    .o_cycle_index (w_ci),
    .o_cycle_clk   (w_last)
  );

  // Next-block bookkeeping and the chunk that belongs to the following clock.
  always_comb begin
    w_case_last = ({1'b0, r_case_idx} == (r_num_cases - NC_W'(1)));
    if (w_case_last) begin
      w_next_idx = '0;
    end else begin
      w_next_idx = r_case_idx + CASE_W'(1);
    end
    if (r_epoch == '1) begin
      w_epoch_inc = r_epoch;
    end else begin
      w_epoch_inc = r_epoch + EP_W'(1);
    end
    if (w_busy) begin
      w_rd_idx = w_next_idx;
    end else begin
      w_rd_idx = '0;
    end
    w_rd        = r_buf[w_rd_idx];
    w_nk        = w_ci + CI_W'(1);
    w_has_chunk = (w_nk <= CI_W'(CPC - 3));
    if (w_has_chunk) begin
      w_sel = CI_W'(CPC - 3) - w_nk;
    end else begin
      w_sel = '0;
    end
    w_end_run = r_stop | bus.stop |
                (w_case_last & (r_num_epochs != '0) & (w_epoch_inc == r_num_epochs));
  end

  // Case storage is deliberately outside reset so programmed cases survive it.
  always_ff @(posedge clk) begin
    if (bus.wr_en && !w_busy) begin
      r_buf[bus.wr_addr] <= {bus.wr_a, bus.wr_y};
    end
  end

  // Run control; a start spends one clock pending so a same-clock write lands first.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pend       <= 1'b0;
      r_stop       <= 1'b0;
      r_valid      <= 1'b0;
      r_case_start <= 1'b0;
      r_wr_err     <= 1'b0;
      r_num_cases  <= '0;
      r_num_epochs <= '0;
      r_epoch      <= '0;
      r_case_idx   <= '0;
      r_sh_a       <= '0;
      r_sh_y       <= '0;
      r_a_in       <= '0;
      r_y_in       <= '0;
    end else begin
      r_wr_err     <= bus.wr_en & w_busy;
      r_case_start <= 1'b0;
      case (r_state)
        IDLE, DONE: begin
          r_a_in  <= '0;
          r_y_in  <= '0;
          r_valid <= 1'b0;
          if (r_pend) begin
            r_pend       <= 1'b0;
            r_state      <= RUN;
            r_stop       <= 1'b0;
            r_case_idx   <= '0;
            r_epoch      <= '0;
            r_sh_a       <= w_rd[BUF_W-1:N_OUT];
            r_sh_y       <= w_rd[N_OUT-1:0];
            r_a_in       <= w_rd[BUF_W-1 -: AIN_W];
            r_y_in       <= w_rd[N_OUT-1 -: YIN_W];
            r_valid      <= 1'b1;
            r_case_start <= 1'b1;
          end else if (bus.start) begin
            if (bus.num_cases == '0) begin
              r_state <= DONE;
            end else begin
              r_pend       <= 1'b1;
              r_num_cases  <= bus.num_cases;
              r_num_epochs <= bus.num_epochs;
            end
          end
        end
        RUN: begin
          if (bus.stop) begin
            r_stop <= 1'b1;
          end
          if (w_last) begin
            if (w_case_last) begin
              r_epoch <= w_epoch_inc;
            end
            if (w_end_run) begin
              r_state <= DONE;
              r_stop  <= 1'b0;
              r_a_in  <= '0;
              r_y_in  <= '0;
              r_valid <= 1'b0;
            end else begin
              r_case_idx   <= w_next_idx;
              r_sh_a       <= w_rd[BUF_W-1:N_OUT];
              r_sh_y       <= w_rd[N_OUT-1:0];
              r_a_in       <= w_rd[BUF_W-1 -: AIN_W];
              r_y_in       <= w_rd[N_OUT-1 -: YIN_W];
              r_valid      <= 1'b1;
              r_case_start <= 1'b1;
            end
          end else if (w_has_chunk) begin
            r_a_in  <= r_sh_a[AIN_W*w_sel +: AIN_W];
            r_y_in  <= r_sh_y[YIN_W*w_sel +: YIN_W];
            r_valid <= 1'b1;
          end else begin
            r_a_in  <= '0;
            r_y_in  <= '0;
            r_valid <= 1'b0;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  assign bus.wr_err      = r_wr_err;
  assign bus.a_in        = r_a_in;
  assign bus.y_in        = r_y_in;
  assign bus.valid       = r_valid;
  assign bus.case_start  = r_case_start;
  assign bus.cycle_index = w_ci;
  assign bus.case_idx    = r_case_idx;
  assign bus.epoch       = r_epoch;
  assign bus.busy        = w_busy;
  assign bus.done        = (r_state == DONE);

endmodule

// File: tb/tb_train_data_feeder.sv
// Randomised bench for train_data_feeder: a case-level model predicts every
// clock of the output stream from the programmed cases and run settings.
module tb_train_data_feeder;

  localparam int TB_CPC = 6;
  localparam int TB_AW  = 16;

  logic clk;
  logic reset;
  int n_checks = 0;
  int n_errors = 0;
  int cs_cnt   = 0;
  int inj_stop_blk = -1, inj_stop_k = 0;
  int inj_wr_blk   = -1, inj_wr_k   = 0;
  int inj_rst_blk  = -1, inj_rst_k  = 0;

  logic [63:0] m_a [32];
  logic [3:0]  m_y [32];

  train_data_feeder_if bus ();

  train_data_feeder dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [45:0] dut_vec();
    return {bus.wr_err, bus.a_in, bus.y_in, bus.valid, bus.case_start,
            bus.cycle_index, bus.case_idx, bus.epoch, bus.busy, bus.done};
  endfunction

  // Reference: clock k of a block carries chunk (cpc-3-k) of the case, MSB first.
  function automatic logic [45:0] exp_vec(int ci, int ep, int k, bit werr);
    logic [15:0] xa;
    logic        xy, xv;
    if (k <= TB_CPC - 3) begin
      xa = 16'(m_a[ci] >> (TB_AW * (TB_CPC - 3 - k)));
      xy = m_y[ci][TB_CPC - 3 - k];
      xv = 1'b1;
    end else begin
      xa = 16'h0;
      xy = 1'b0;
      xv = 1'b0;
    end
    return {werr, xa, xy, xv, (k == 0), 3'(k), 5'(ci), 16'(ep), 1'b1, 1'b0};
  endfunction

  task automatic write_case(input int addr, input logic [63:0] a, input logic [3:0] y);
    bus.wr_en = 1'b1; bus.wr_addr = 5'(addr); bus.wr_a = a; bus.wr_y = y;
    tick;
    bus.wr_en = 1'b0;
    m_a[addr] = a; m_y[addr] = y;
  endtask

  task automatic play(input int nc, input int ne, input bit started);
    int blk, ci, ep;
    bit fin, wr_prev, wr_now;
    logic [45:0] ev;
    logic [40:0] got_d, exp_d;
    if (!started) begin
      bus.num_cases = 6'(nc); bus.num_epochs = 16'(ne); bus.start = 1'b1;
      tick;
      bus.start = 1'b0;
    end
    tick;
    blk = 0; ci = 0; ep = 0; fin = 1'b0; wr_prev = 1'b0;
    while (!fin) begin
      for (int k = 0; k < TB_CPC; k++) begin
        ev = exp_vec(ci, ep, k, wr_prev);
        n_checks++;
        if (dut_vec() !== ev) begin
          n_errors++;
          $display("FAIL stream blk=%0d k=%0d got=%h exp=%h", blk, k, dut_vec(), ev);
        end
        if (bus.case_start === 1'b1) cs_cnt++;
        wr_now = (blk == inj_wr_blk) && (k == inj_wr_k);
        if (wr_now) begin
          bus.wr_en = 1'b1; bus.wr_addr = 5'd3;
          bus.wr_a = {$urandom, $urandom}; bus.wr_y = 4'($urandom);
        end
        if (blk == inj_stop_blk && k == inj_stop_k) bus.stop = 1'b1;
        if (blk == inj_rst_blk && k == inj_rst_k) begin
          reset = 1'b1;
          tick;
          reset = 1'b0;
          n_checks++;
          if (dut_vec() !== 46'h0) begin
            n_errors++;
            $display("FAIL reset_mid got=%h exp=0", dut_vec());
          end
          return;
        end
        tick;
        bus.stop = 1'b0; bus.wr_en = 1'b0; wr_prev = wr_now;
      end
      blk++; ci++;
      if (ci == nc) begin
        ci = 0;
        if (ep != 65535) ep++;
      end
      if ((inj_stop_blk >= 0 && blk > inj_stop_blk) || (ne != 0 && ci == 0 && ep == ne)) fin = 1'b1;
    end
    got_d = {bus.wr_err, bus.a_in, bus.y_in, bus.valid, bus.case_start,
             bus.cycle_index, bus.epoch, bus.busy, bus.done};
    exp_d = {wr_prev, 16'h0, 1'b0, 1'b0, 1'b0, 3'd0, 16'(ep), 1'b0, 1'b1};
    n_checks++;
    if (got_d !== exp_d) begin
      n_errors++;
      $display("FAIL run_end blocks=%0d got=%h exp=%h", blk, got_d, exp_d);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1; bus.wr_en = 1'b0; bus.wr_addr = 5'd0; bus.wr_a = 64'h0; bus.wr_y = 4'h0;
    bus.start = 1'b0; bus.stop = 1'b0; bus.num_cases = 6'd0; bus.num_epochs = 16'd0;
    tick; tick; tick;
    reset = 1'b0;
    n_checks++;
    if (dut_vec() !== 46'h0) begin
      n_errors++;
      $display("FAIL reset_state got=%h exp=0", dut_vec());
    end
  endtask

  task automatic test_zero_cases;
    bit seen_valid;
    bus.num_cases = 6'd0; bus.num_epochs = 16'd1; bus.start = 1'b1;
    tick;
    bus.start = 1'b0;
    n_checks++;
    if ({bus.done, bus.busy, bus.valid} !== 3'b100) begin
      n_errors++;
      $display("FAIL zero_cases done/busy/valid got=%b exp=100", {bus.done, bus.busy, bus.valid});
    end
    seen_valid = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick;
      if (bus.valid !== 1'b0) seen_valid = 1'b1;
    end
    n_checks++;
    if (seen_valid) begin
      n_errors++;
      $display("FAIL zero_cases_valid got=1 exp=0");
    end
  endtask

  task automatic test_single;
    write_case(0, 64'h000000f000000000, 4'b0100);
    play(1, 1, 1'b0);
  endtask

  task automatic test_epochs;
    for (int i = 0; i < 32; i++) write_case(i, {$urandom, $urandom}, 4'($urandom));
    cs_cnt = 0;
    play(32, 3, 1'b0);
    n_checks++;
    if (cs_cnt !== 96) begin
      n_errors++;
      $display("FAIL case_start_count got=%0d exp=96", cs_cnt);
    end
  endtask

  task automatic test_stop;
    inj_stop_blk = 5; inj_stop_k = 2;
    play(10, 1, 1'b0);
    inj_stop_blk = -1;
  endtask

  task automatic test_wr_err;
    inj_wr_blk = 1; inj_wr_k = 2;
    play(4, 2, 1'b0);
    inj_wr_blk = -1;
  endtask

  task automatic test_reset_mid;
    inj_rst_blk = 1; inj_rst_k = 3;
    play(3, 0, 1'b0);
    inj_rst_blk = -1;
    play(3, 1, 1'b0);
  endtask

  task automatic test_unlimited;
    inj_stop_blk = 200; inj_stop_k = 4;
    play(2, 0, 1'b0);
    inj_stop_blk = -1;
  endtask

  task automatic test_back_to_back;
    logic [63:0] a;
    logic [3:0]  y;
    a = {$urandom, $urandom}; y = 4'($urandom);
    bus.wr_en = 1'b1; bus.wr_addr = 5'd0; bus.wr_a = a; bus.wr_y = y;
    bus.num_cases = 6'd1; bus.num_epochs = 16'd2; bus.start = 1'b1;
    tick;
    bus.wr_en = 1'b0; bus.start = 1'b0;
    m_a[0] = a; m_y[0] = y;
    play(1, 2, 1'b1);
  endtask

  initial begin
    test_reset;
    test_zero_cases;
    test_single;
    test_epochs;
    test_stop;
    test_wr_err;
    test_reset_mid;
    test_unlimited;
    test_back_to_back;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/train_data_feeder.md
Name: train_data_feeder

Overview:
- Upstream stimulus stage for DNN.
- Holds a programmable set of 1-bit training cases: a 64-bit activation vector and a 4-bit ideal output per case.
- Replays the cases case-by-case, epoch-by-epoch, slicing each case into per-clock a_in / y_in chunks aligned to the DNN cycle block of cpc clocks.
- Replaces the behavioural mux/counter feeding, so the DNN can be driven from RTL (FPGA bring-up).

Parameters:
n_in, 64, input neurons n[0]
n_out, 4, output neurons n[L-1]
ain_w, 16, activations per clock z[0]/fo[0]
yin_w, 1, ideal outputs per clock z[L-2]/fi[L-2]
cpc, 6, clocks per cycle block, n_in/ain_w + 2
max_cases, 32, case buffer depth
ep_w, 16, epoch counter width

Ports:
clk  in  1  clock
reset  in  1  synchronous active-high reset
wr_en  in  1  case-buffer write strobe
wr_addr  in  clog2(max_cases)  case slot
wr_a  in  n_in  activation vector
wr_y  in  n_out  ideal output vector
wr_err  out  1  1-clk pulse: write attempted while busy
start  in  1  begin run (IDLE or DONE)
stop  in  1  finish at end of current case block
num_cases  in  clog2(max_cases+1)  cases per epoch, sampled at start
num_epochs  in  ep_w  epochs to run, 0 = unlimited, sampled at start
a_in  out  ain_w  activation chunk to DNN
y_in  out  yin_w  ideal-output chunk to DNN
valid  out  1  a_in/y_in carry a data chunk this clock
case_start  out  1  high in cycle_index 0 of each case
cycle_index  out  clog2(cpc)  position within block, 0..cpc-1
case_idx  out  clog2(max_cases)  current case
epoch  out  ep_w  completed-epoch count
busy  out  1  state == RUN
done  out  1  state == DONE

Behaviour:
- Reset: all outputs 0. State goes to IDLE; counters and the stop latch clear. The case buffer is not reset and keeps its contents, including on reset mid-run.
- States and transitions:
  - IDLE: start with num_cases>0 -> RUN. start with num_cases==0 -> DONE.
  - RUN: advances blocks as below.
  - DONE: done=1 held. start -> RUN (same rules as IDLE).
- Writes: accepted in IDLE/DONE, buffer[wr_addr] <= {wr_a, wr_y} at clock edge. wr_en in RUN is ignored and pulses wr_err next clock. Simultaneous start+wr_en in IDLE: the write is committed first, so the run sees the new data.
- Run start latency:
  - start sampled at edge t.
  - At edge t+1: case 0 loaded into shadow registers, cycle_index=0, case_idx=0, epoch=0.
  - Outputs are registered; the first chunk is visible after edge t+1.
- Chunk order in cycle_index k, for k = 0..cpc-3:
  - chunk index c = cpc-3-k.
  - a_in = shadow_a[ain_w*(c+1)-1 : ain_w*c]; y_in = shadow_y[yin_w*(c+1)-1 : yin_w*c]. MSB chunk first.
  - valid=1.
- Cycles cpc-2 and cpc-1: a_in=0, y_in=0, valid=0 (DNN drains).
- Next case: at the edge ending cycle cpc-1, case_idx+1 and its vectors load into the shadow registers. No bubble between blocks.
- Wrap: case_idx==num_cases-1 -> case_idx=0, epoch+1 (saturates at all-ones).
- Termination: when epoch reaches num_epochs (nonzero), enter DONE instead of starting the next block.
- stop: latched any time in RUN. At the end of the current block, enter DONE. stop and epoch completion in the same clock give DONE (same outcome).
- start while in RUN is ignored.
- Elaboration-time check: n_in/ain_w == n_out/yin_w == cpc-2; otherwise $error.

Decomposition:
- Package dnn_feeder_pkg:
  - function calc_cpc(n, fo, z);
  - chunk-count function;
  - state enum {IDLE, RUN, DONE}.
- Sub-module: reuse the existing cycle_block_counter for cycle_index/cycle_clk. Its reset is driven as reset | ~busy.
- Case buffer: plain register array with no reset, read combinationally into the shadow registers.

Test Plan:
- Program case 0 a=64'h000000f000000000, y=4'b0100; num_cases=1, num_epochs=1; start -> a_in = 0000,00f0,0000,0000 then 0,0; y_in = 0,1,0,0; valid = 1,1,1,1,0,0; done rises after 6 clocks of RUN.
- Program 32 cases, num_epochs=3 -> case_idx wraps 31->0 twice; epoch = 1,2,3; done after 3*32*6=576 RUN clocks; case_start count 96.
- stop asserted at cycle_index 2 of case 5 -> case 5 completes through cycle_index 5, then DONE; case 6 is never output.
- wr_en during RUN with wr_addr=3 -> wr_err pulses once; case 3 data unchanged on the next epoch.
- reset asserted mid-block -> next clock all outputs 0, IDLE; restart reproduces the original case 0 data (buffer retained).
- num_cases=0 with start -> DONE next clock, valid never asserted. num_epochs=0 -> runs past 1000 clocks until stop.
